// File: rtl/apb_cmd_queue_if.sv
// Processor command/response channels plus the APB master launch signals and
// bus taps used by apb_cmd_queue. The queue sits on the slave modport; the
// driving side (processor, APB master/slave) uses the master modport.
interface apb_cmd_queue_if #(
  parameter int DEPTH = 4
);
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  // launch side towards the APB master
  logic        SWRITE;
  logic [31:0] SADDR;
  logic [31:0] SWDATA;
  logic        transfer;
  // APB bus taps
  logic        PSEL;
  logic        PENABLE;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  // status
  logic        busy;
  logic [$clog2(DEPTH+1)-1:0] cmd_count;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    input  rsp_ready,
    output cmd_ready, SWRITE, SADDR, SWDATA, transfer,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout,
    output busy, cmd_count
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
    output rsp_ready,
    input  cmd_ready, SWRITE, SADDR, SWDATA, transfer,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout,
    input  busy, cmd_count
  );
endinterface

// File: rtl/apb_cmd_queue.sv
// Command FIFO + single-outstanding launcher in front of the APB master.
// Pops one command when the bus is idle, waits for PSEL&PENABLE&PREADY (or the
// watchdog), and presents exactly one response per command, in order.
module apb_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input logic            PCLK,
  input logic            PRESETn,
  apb_cmd_queue_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_wdog;
  state_t        r_state, w_state_nxt;

  logic w_full, w_empty, w_push, w_pop, w_done, w_expire;
  cmd_t w_in, w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = bus.cmd_valid & ~w_full;
  assign w_in     = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  assign w_head   = r_mem[r_rptr];
  assign w_done   = bus.PSEL & bus.PENABLE & bus.PREADY;
  // A watchdog of 0 never expires; completion is checked first below so it wins ties.
  assign w_expire = (TIMEOUT != 0) && (r_wdog == TW'(TLIM));

  assign bus.cmd_ready = ~w_full;
  assign bus.cmd_count = r_count;
  assign bus.busy      = (r_state != S_IDLE) | ~w_empty;

  // Next state and pop decode; launch only when the bus has gone quiet.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty && !bus.PSEL) begin
        w_pop       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (w_done || w_expire) w_state_nxt = S_RESP;
      S_RESP: if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge PCLK)
    if (w_push) r_mem[r_wptr] <= w_in;

  // FIFO pointers and occupancy; simultaneous push/pop leaves the count alone.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end

  // Launch: one-cycle transfer pulse; command fields held until the next launch.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      bus.transfer <= 1'b0;
      bus.SWRITE   <= 1'b0;
      bus.SADDR    <= '0;
      bus.SWDATA   <= '0;
    end else begin
      bus.transfer <= w_pop;
      if (w_pop) begin
        bus.SWRITE <= w_head.write;
        bus.SADDR  <= w_head.addr;
        bus.SWDATA <= w_head.wdata;
      end
    end

  // Watchdog: cleared at launch, counts every cycle spent in WAIT.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn)                          r_wdog <= '0;
    else if (w_pop)                        r_wdog <= '0;
    else if (r_state == S_WAIT && !w_expire) r_wdog <= r_wdog + 1'b1;

  // Response capture on completion or expiry; held until consumed.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_write   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else if (r_state == S_WAIT && w_done) begin
      bus.rsp_valid   <= 1'b1;
      bus.rsp_write   <= bus.SWRITE;
      bus.rsp_rdata   <= bus.SWRITE ? 32'd0 : bus.PRDATA;
      bus.rsp_err     <= bus.PSLVERR;
      bus.rsp_timeout <= 1'b0;
    end else if (r_state == S_WAIT && w_expire) begin
      bus.rsp_valid   <= 1'b1;
      bus.rsp_write   <= bus.SWRITE;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b1;
      bus.rsp_timeout <= 1'b1;
    end else if (r_state == S_RESP && bus.rsp_ready) begin
      bus.rsp_valid   <= 1'b0;
    end
endmodule

// File: tb/tb_apb_cmd_queue.sv
// Directed bench for apb_cmd_queue: a small behavioural APB master+slave
// reacts to transfer pulses; the main sequence checks hand-derived values.
module tb_apb_cmd_queue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  apb_cmd_queue_if #(.DEPTH(DEPTH)) bus();

  apb_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.slave)
  );

  always #5 PCLK = ~PCLK;

  int          n_vec = 0, n_err = 0, n_launch = 0, n_rsp = 0;
  logic [31:0] mem [0:63];
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          slv_wait = 0;
  logic        hang = 1'b0;

  // Behavioural APB master + slave: transfer -> setup -> access (+waits) -> done.
  logic s_tr, s_sel, s_en, s_rdy;
  int   wcnt;
  always @(posedge PCLK) begin
    s_tr  = bus.transfer;
    s_sel = bus.PSEL;
    s_en  = bus.PENABLE;
    s_rdy = bus.PREADY;
    #1;
    if (!PRESETn) begin
      bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0; bus.PSLVERR = 0; bus.PRDATA = '0;
    end else if (s_sel && s_en && s_rdy) begin
      if (bus.SWRITE) mem[bus.SADDR[7:2]] = bus.SWDATA;
      bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0; bus.PSLVERR = 0;
    end else if (s_sel && !s_en) begin
      bus.PENABLE = 1;
      wcnt        = slv_wait;
      bus.PREADY  = (slv_wait == 0) && !hang;
      bus.PRDATA  = (bus.SADDR == err_addr) ? 32'hBAD0_BAD0 : mem[bus.SADDR[7:2]];
      bus.PSLVERR = bus.PREADY && (bus.SADDR == err_addr);
    end else if (s_sel && s_en) begin
      if (!hang) begin
        if (wcnt > 1) wcnt--;
        else          bus.PREADY = 1;
      end
      bus.PSLVERR = bus.PREADY && (bus.SADDR == err_addr);
    end else if (s_tr) begin
      bus.PSEL = 1;
      n_launch++;
    end
  end

  // Response handshake counter.
  always @(posedge PCLK)
    if (PRESETn && bus.rsp_valid && bus.rsp_ready) n_rsp++;

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, bus.rsp_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic        exp_w [5];
    logic [31:0] exp_d [5];
    int          base_rsp, base_launch;
    exp_w = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_d = '{32'h0, 32'h0, 32'h11, 32'h22, 32'hCAFE_F00D};

    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 0;

    // reset values
    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_cmd_count", bus.cmd_count, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_transfer",  bus.transfer, 0);
    chk("rst_saddr",     bus.SADDR, 0);
    chk("rst_swdata",    bus.SWDATA, 0);
    chk("rst_swrite",    bus.SWRITE, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err",   bus.rsp_err, 0);
    chk("rst_rsp_to",    bus.rsp_timeout, 0);
    PRESETn = 1;
    tick();

    // single write, zero-wait, exact latency
    bus.rsp_ready = 1;
    push(1, 32'h10, 32'hDEAD_BEEF);             // edge 0
    chk("t1_count_e0", bus.cmd_count, 1);
    chk("t1_xfer_e0",  bus.transfer, 0);
    chk("t1_busy_e0",  bus.busy, 1);
    tick();                                     // edge 1
    chk("t1_xfer_e1",  bus.transfer, 1);
    chk("t1_swrite",   bus.SWRITE, 1);
    chk("t1_count_e1", bus.cmd_count, 0);
    tick();                                     // edge 2
    chk("t1_xfer_e2",  bus.transfer, 0);
    tick();                                     // edge 3: access phase
    chk("t1_saddr_acc",  bus.SADDR, 32'h10);
    chk("t1_swdata_acc", bus.SWDATA, 32'hDEAD_BEEF);
    chk("t1_valid_e3",   bus.rsp_valid, 0);
    tick();                                     // edge 4
    chk("t1_valid_e4", bus.rsp_valid, 1);
    chk("t1_write",    bus.rsp_write, 1);
    chk("t1_rdata",    bus.rsp_rdata, 0);
    chk("t1_err",      bus.rsp_err, 0);
    chk("t1_to",       bus.rsp_timeout, 0);
    tick();                                     // edge 5
    chk("t1_valid_e5", bus.rsp_valid, 0);
    chk("t1_busy_e5",  bus.busy, 0);
    chk("t1_launches", n_launch, 1);

    // write then read back, in order
    push(1, 32'h20, 32'hCAFE_F00D);
    push(0, 32'h20, 32'h0);
    wait_rsp("t2_rsp1");
    chk("t2_w1",   bus.rsp_write, 1);
    chk("t2_err1", bus.rsp_err, 0);
    tick();
    wait_rsp("t2_rsp2");
    chk("t2_w2",   bus.rsp_write, 0);
    chk("t2_rd2",  bus.rsp_rdata, 32'hCAFE_F00D);
    chk("t2_err2", bus.rsp_err, 0);
    tick();

    // fill the FIFO behind a stalled response
    bus.rsp_ready = 0;
    base_rsp = n_rsp;
    push(1, 32'h40, 32'h11);
    push(1, 32'h44, 32'h22);
    push(0, 32'h40, 32'h0);
    push(0, 32'h44, 32'h0);
    push(0, 32'h20, 32'h0);
    chk("t3_count_full", bus.cmd_count, 4);
    chk("t3_ready_full", bus.cmd_ready, 0);
    chk("t3_busy",       bus.busy, 1);
    push(1, 32'h48, 32'h99);                    // refused
    chk("t3_count_hold", bus.cmd_count, 4);
    chk("t3_rsp_held",   bus.rsp_valid, 1);
    bus.rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp($sformatf("t3_rsp%0d", i));
      chk($sformatf("t3_w%0d", i), bus.rsp_write, exp_w[i]);
      chk($sformatf("t3_d%0d", i), bus.rsp_rdata, exp_d[i]);
      tick();
    end
    repeat (10) tick();
    chk("t3_nrsp",   n_rsp - base_rsp, 5);
    chk("t3_count0", bus.cmd_count, 0);
    chk("t3_idle",   bus.busy, 0);

    // slave error on a read, next command proceeds (one wait state each)
    err_addr = 32'h3C;
    slv_wait = 1;
    push(0, 32'h3C, 32'h0);
    push(1, 32'h50, 32'h55);
    wait_rsp("t4_rsp1");
    chk("t4_err1",  bus.rsp_err, 1);
    chk("t4_to1",   bus.rsp_timeout, 0);
    chk("t4_w1",    bus.rsp_write, 0);
    chk("t4_rd1",   bus.rsp_rdata, 32'hBAD0_BAD0);
    tick();
    wait_rsp("t4_rsp2");
    chk("t4_err2",  bus.rsp_err, 0);
    chk("t4_w2",    bus.rsp_write, 1);
    tick();
    slv_wait = 0;
    err_addr = 32'hFFFF_FFFF;

    // watchdog: PREADY never rises
    hang = 1;
    base_launch = n_launch;
    push(0, 32'h60, 32'h0);                     // edge 0
    push(1, 32'h64, 32'h77);                    // edge 1: launch enters WAIT
    chk("t5_xfer", bus.transfer, 1);
    repeat (7) tick();                          // edge 8
    chk("t5_valid_e8", bus.rsp_valid, 0);
    tick();                                     // edge 9
    chk("t5_valid_e9", bus.rsp_valid, 1);
    chk("t5_err",      bus.rsp_err, 1);
    chk("t5_to",       bus.rsp_timeout, 1);
    chk("t5_rdata",    bus.rsp_rdata, 0);
    chk("t5_w",        bus.rsp_write, 0);
    repeat (6) tick();
    chk("t5_no_launch", n_launch - base_launch, 1);
    chk("t5_queued",    bus.cmd_count, 1);
    chk("t5_busy",      bus.busy, 1);
    hang = 0;
    wait_rsp("t5_next");
    chk("t5_next_err", bus.rsp_err, 0);
    chk("t5_next_to",  bus.rsp_timeout, 0);
    chk("t5_next_w",   bus.rsp_write, 1);
    chk("t5_launch2",  n_launch - base_launch, 2);
    tick();

    // reset while in WAIT with 3 queued
    hang = 1;
    push(1, 32'h70, 32'h1);
    push(1, 32'h74, 32'h2);
    push(0, 32'h70, 32'h0);
    push(0, 32'h74, 32'h0);
    chk("t6_count3", bus.cmd_count, 3);
    #1 PRESETn = 0;
    #1;
    chk("t6_count", bus.cmd_count, 0);
    chk("t6_ready", bus.cmd_ready, 1);
    chk("t6_busy",  bus.busy, 0);
    chk("t6_saddr", bus.SADDR, 0);
    chk("t6_swr",   bus.SWRITE, 0);
    chk("t6_valid", bus.rsp_valid, 0);
    hang = 0;
    base_rsp    = n_rsp;
    base_launch = n_launch;
    repeat (2) tick();
    PRESETn = 1;
    repeat (15) tick();
    chk("t6_no_rsp",    n_rsp - base_rsp, 0);
    chk("t6_no_launch", n_launch - base_launch, 0);
    chk("t6_idle",      bus.busy, 0);
    push(0, 32'h20, 32'h0);
    wait_rsp("t6_after");
    chk("t6_after_rd", bus.rsp_rdata, 32'hCAFE_F00D);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
